// File: rtl/div_seq.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU with its own sequencing FSM.
// Returns {remainder, quotient} and requests an EX stall while a divide is in flight.
module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_div,
   input  logic        annul,
   input  logic [31:0] opdata1,
   input  logic [31:0] opdata2,
   output logic [63:0] result,
   output logic        ready,
   output logic        stallreq
);

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BYZERO = 2'b01;
   localparam logic [1:0] ON     = 2'b10;
   localparam logic [1:0] DONE   = 2'b11;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [64:0] work;       // {rem[32:0], quo[31:0]}
   logic [31:0] divisor;
   logic        qneg;
   logic        rneg;

   logic [31:0] abs1;
   logic [31:0] abs2;
   logic [64:0] shifted;
   logic [33:0] diff;
   logic [64:0] work_nxt;
   logic [31:0] quo_fin;
   logic [31:0] rem_fin;
   logic        abort;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      abs1     = opdata1;
      abs2     = opdata2;
      if (signed_div && opdata1[31]) abs1 = -opdata1;
      if (signed_div && opdata2[31]) abs2 = -opdata2;

      shifted  = work << 1;
      // One extra bit so a negative trial difference is visible in diff[33].
      diff     = {1'b0, shifted[64:32]} - {2'b00, divisor};
      work_nxt = shifted;
      if (!diff[33]) work_nxt = {diff[32:0], shifted[31:1], 1'b1};

      quo_fin  = qneg ? -work_nxt[31:0]  : work_nxt[31:0];
      rem_fin  = rneg ? -work_nxt[63:32] : work_nxt[63:32];
   end

   assign abort    = annul | ~start;
   assign stallreq = start & ~annul & (state != DONE);

   // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous
   // so a flush-by-reset clears ready/result without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 6'd0;
         work    <= 65'd0;
         divisor <= 32'd0;
         qneg    <= 1'b0;
         rneg    <= 1'b0;
         result  <= 64'h0;
         ready   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
               if (start && !annul) begin
                  cnt     <= 6'd0;
                  divisor <= abs2;
                  work    <= {33'd0, abs1};
                  qneg    <= signed_div & (opdata1[31] ^ opdata2[31]);
                  rneg    <= signed_div & opdata1[31];
                  state   <= (opdata2 == 32'd0) ? BYZERO : ON;
               end
            end
            BYZERO: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  state  <= DONE;
                  ready  <= 1'b1;
                  result <= 64'h0;
               end
            end
            ON: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  work <= work_nxt;
                  cnt  <= cnt + 6'd1;
                  if (cnt == 6'd31) begin
                     state  <= DONE;
                     ready  <= 1'b1;
                     result <= {rem_fin, quo_fin};
                  end
               end
            end
            DONE: begin
               if (abort) begin
                  state <= IDLE;
                  ready <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
